// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding,
// register-index width, the PC register index and the source/destination
// match helper used by the hazard detector.
package hazard_ctrl_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] PC_IDX = 4'd15;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    // True when the ID instruction reads register dest through either source.
    // PC_IDX gets no special treatment; it compares like any other index.
    function automatic logic src_match(
        input logic [REG_W-1:0] src1,
        input logic [REG_W-1:0] src2,
        input logic             two_src,
        input logic [REG_W-1:0] dest
    );
        return (src1 == dest) | (two_src & (src2 == dest));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, hold at all-ones, clear synchronously.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: decides per cycle whether PC, IF/ID and ID/EX advance,
// freeze or flush. Priority is memory wait > taken branch > data hazard.
// Optional build macro: FORWARDING_EN (restricts data hazards to load-use).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             freeze_all,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_ONE  = TW'(1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

    state_t        state_r;
    state_t        state_s;
    logic [TW-1:0] wait_r;
    logic [TW-1:0] wait_s;
    logic          exe_match_s;
    logic          hz_s;

    assign exe_match_s = src_match(id_src1, id_src2, id_two_src, exe_dest);

`ifdef FORWARDING_EN
    // ALU results are forwarded, so only a load in EXE can block ID.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{mem_dest, mem_wb_en};
    assign hz_s = id_valid & exe_wb_en & exe_mem_read & exe_match_s;
`else
    // No forwarding: any pending write in EXE or MEM blocks a reader in ID.
    logic mem_match_s;
    logic unused_fwd_s;
    assign unused_fwd_s = exe_mem_read;
    assign mem_match_s  = src_match(id_src1, id_src2, id_two_src, mem_dest);
    assign hz_s = id_valid & ((exe_wb_en & exe_match_s) | (mem_wb_en & mem_match_s));
`endif

    // State and memory-wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            wait_r  <= {TW{1'b0}};
        end else begin
            state_r <= state_s;
            wait_r  <= wait_s;
        end
    end

    // Next-state and zero-latency control outputs.
    always_comb begin
        state_s      = state_r;
        wait_s       = wait_r;
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        freeze_all   = 1'b0;
        mem_timeout  = 1'b0;
        if (rst) begin
            state_s = RUN;
            wait_s  = {TW{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        freeze_all = 1'b1;
                        state_s    = MEM_WAIT;
                        wait_s     = WAIT_ONE;
                    end else if (branch_taken) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (hz_s) begin
                        freeze_pc    = 1'b1;
                        freeze_if_id = 1'b1;
                        flush_id_ex  = 1'b1;
                    end else begin
                        state_s = RUN;
                    end
                end
                MEM_WAIT: begin
                    // Branch and hazard are masked: EXE is frozen, so both
                    // are re-evaluated once the access completes.
                    freeze_all = 1'b1;
                    if (mem_ready) begin
                        state_s = RUN;
                    end else begin
                        wait_s = wait_r + WAIT_ONE;
                        if (wait_r >= WAIT_LAST) begin
                            state_s = TIMEOUT;
                        end else begin
                            state_s = MEM_WAIT;
                        end
                    end
                end
                TIMEOUT: begin
                    freeze_all  = 1'b1;
                    mem_timeout = 1'b1;
                end
                default: begin
                    state_s = RUN;
                    wait_s  = {TW{1'b0}};
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (freeze_pc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (flush_if_id),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with a behavioural reference model and
// an expected-result queue. Follows FORWARDING_EN of the build.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CW   = 4;
    localparam int TO   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, id_valid, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
    logic mem_req, mem_ready, branch_taken;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_all, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_count;

    hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_two_src(id_two_src), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .freeze_pc(freeze_pc),
        .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .freeze_all(freeze_all),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    typedef struct packed {
        logic [5:0]    ctl;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int m_state = 0;
    int m_wait  = 0;
    int m_stall = 0;
    int m_flush = 0;
    int fall_seen = 0;

    function automatic bit m_hz();
        bit e, m;
        e = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
        m = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));
`ifdef FORWARDING_EN
        return id_valid && exe_wb_en && exe_mem_read && e;
`else
        return id_valid && ((exe_wb_en && e) || (mem_wb_en && m));
`endif
    endfunction

    task automatic idle();
        id_valid = 1'b0; id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        branch_taken = 1'b0;
    endtask

    // One cycle: inputs already set after a negedge; predict, check, advance.
    task automatic cyc(input string name);
        bit fpc, fif, flif, flex, fall, mto;
        exp_t e;
        fpc = 0; fif = 0; flif = 0; flex = 0; fall = 0; mto = 0;
        if (!rst) begin
            if (m_state == 0) begin
                if (mem_req && !mem_ready) fall = 1;
                else if (branch_taken) begin flif = 1; flex = 1; end
                else if (m_hz()) begin fpc = 1; fif = 1; flex = 1; end
            end else if (m_state == 1) begin
                fall = 1;
            end else begin
                fall = 1; mto = 1;
            end
        end
        sb.push_back({fpc, fif, flif, flex, fall, mto, CW'(m_stall), CW'(m_flush)});
        #2;
        e = sb.pop_front();
        checks++;
        if ({freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_all, mem_timeout} !== e.ctl) begin
            errors++;
            $display("FAIL %s ctl: got %b want %b", name,
                {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_all, mem_timeout}, e.ctl);
        end
        checks++;
        if (stall_cycles !== e.stall) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cycles, e.stall);
        end
        checks++;
        if (flush_count !== e.flush) begin
            errors++;
            $display("FAIL %s flush_count: got %0d want %0d", name, flush_count, e.flush);
        end
        if (freeze_all === 1'b1) fall_seen++;
        @(posedge clk);
        if (rst) begin
            m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (fpc && m_stall < CMAX) m_stall++;
            if (flif && m_flush < CMAX) m_flush++;
            if (m_state == 0) begin
                if (mem_req && !mem_ready) begin m_state = 1; m_wait = 1; end
            end else if (m_state == 1) begin
                if (mem_ready) m_state = 0;
                else begin
                    m_wait = m_wait + 1;
                    if (m_wait >= TO) m_state = 2;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_valid = 1'b1; id_src1 = 4'd5; exe_dest = 4'd5; exe_wb_en = 1'b1;
        exe_mem_read = 1'b1; branch_taken = 1'b1; mem_req = 1'b1;
        cyc("reset_busy");
        check_val("reset_stall", stall_cycles, 0);
        check_val("reset_ctl", {freeze_pc, flush_if_id, freeze_all, mem_timeout}, 0);
        idle();
        cyc("reset_idle");
        rst = 1'b0;
        cyc("run_idle");
    endtask

    task automatic test_load_use();
        int s0;
        s0 = stall_cycles;
        id_valid = 1'b1; id_src1 = 4'd1;
        exe_dest = 4'd1; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        cyc("load_use_exe");
        exe_wb_en = 1'b0; exe_mem_read = 1'b0; exe_dest = 4'd0;
        mem_dest = 4'd1; mem_wb_en = 1'b1;
        cyc("load_use_mem");
        idle(); id_valid = 1'b1; id_src1 = 4'd1;
        cyc("load_use_done");
`ifdef FORWARDING_EN
        check_val("load_use_stalls", stall_cycles - s0, 1);
`else
        check_val("load_use_stalls", stall_cycles - s0, 2);
`endif
        idle();
    endtask

    task automatic test_alu_dep();
        int s0;
        for (int two = 1; two >= 0; two--) begin
            s0 = stall_cycles;
            id_valid = 1'b1; id_src1 = 4'd7; id_src2 = 4'd2; id_two_src = two[0];
            exe_dest = 4'd2; exe_wb_en = 1'b1;
            cyc("alu_dep_exe");
            exe_wb_en = 1'b0; exe_dest = 4'd0; mem_dest = 4'd2; mem_wb_en = 1'b1;
            cyc("alu_dep_mem");
            mem_wb_en = 1'b0; mem_dest = 4'd0;
            cyc("alu_dep_done");
`ifdef FORWARDING_EN
            check_val("alu_dep_stalls", stall_cycles - s0, 0);
`else
            check_val("alu_dep_stalls", stall_cycles - s0, two ? 2 : 0);
`endif
            idle();
        end
    endtask

    task automatic test_branch_hazard();
        int f0;
        f0 = flush_count;
        id_valid = 1'b1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
        exe_mem_read = 1'b1; branch_taken = 1'b1;
        cyc("branch_hz");
        idle();
        cyc("branch_after");
        check_val("branch_flush_delta", flush_count - f0, 1);
        id_valid = 1'b1; id_src2 = PC_IDX; id_two_src = 1'b1;
        exe_dest = PC_IDX; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        cyc("pc_idx_hz");
        idle();
    endtask

    task automatic test_mem_wait();
        int f0;
        f0 = flush_count; fall_seen = 0;
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc("mem_wait_1");
        branch_taken = 1'b1;
        cyc("mem_wait_2");
        id_valid = 1'b1; id_src1 = 4'd4; exe_dest = 4'd4; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        cyc("mem_wait_3");
        mem_ready = 1'b1;
        cyc("mem_wait_ready");
        mem_req = 1'b0; mem_ready = 1'b0;
        cyc("mem_wait_branch");
        check_val("mem_wait_freeze_all_cycles", fall_seen, 4);
        check_val("mem_wait_flush_delta", flush_count - f0, 1);
        idle();
    endtask

    task automatic test_timeout();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) cyc("timeout_wait");
        check_val("timeout_sticky", mem_timeout, 1);
        mem_ready = 1'b1;
        cyc("timeout_hold");
        idle(); rst = 1'b1;
        cyc("timeout_rst");
        rst = 1'b0;
        cyc("timeout_after_rst");
        check_val("timeout_cleared", {mem_timeout, freeze_all}, 0);
        check_val("counters_cleared", stall_cycles + flush_count, 0);
    endtask

    task automatic test_saturate();
        id_valid = 1'b1; id_src1 = 4'd9; exe_dest = 4'd9; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        for (int i = 0; i < CMAX + 5; i++) cyc("saturate");
        check_val("stall_saturated", stall_cycles, CMAX);
        idle();
        cyc("saturate_idle");
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_alu_dep();
        test_branch_hazard();
        test_mem_wait();
        test_timeout();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
